// File: rtl/mbc_rtc_pkg.sv
// Shared definitions for the MBC3/MBC30 RTC backup sequencer: state encoding,
// trailer geometry, save word order and the optional checksum (MBC_RTC_CHKSUM_EN).
package mbc_rtc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_WORD   = 3'd1,
    LD_COMMIT = 3'd2,
    LD_FIN    = 3'd3,
    SV_SNAP   = 3'd4,
    SV_WORD   = 3'd5,
    SV_FIN    = 3'd6
  } seq_state_e;

  localparam int unsigned LD_WORDS    = 4;
  localparam int unsigned COMMIT_ADDR = 4;

  localparam logic [16:0] COMMIT_BK_ADDR = 17'(COMMIT_ADDR);

  localparam int unsigned      CHK_W    = 16;
  localparam logic [CHK_W-1:0] CHK_INIT = '0;

  // Save word order: slices of the {savedtime[31:0], timestamp} snapshot
  localparam logic [2:0] WI_TS_LO = 3'd0;
  localparam logic [2:0] WI_TS_HI = 3'd1;
  localparam logic [2:0] WI_ST_LO = 3'd2;
  localparam logic [2:0] WI_ST_HI = 3'd3;

`ifdef MBC_RTC_CHKSUM_EN
  localparam logic [2:0]  WI_CHK     = 3'd4;
  localparam int unsigned SV_WORDS   = LD_WORDS + 1;
  localparam logic [15:0] LD_CHK_IDX = 16'(LD_WORDS);

  function automatic logic [CHK_W-1:0] rtc_chk(input logic [63:0] snap);
    logic [CHK_W-1:0] s;
    s = CHK_INIT;
    for (int i = 0; i < 4; i++) s = s + snap[i*16 +: 16];
    return ~s;
  endfunction
`else
  localparam int unsigned SV_WORDS    = LD_WORDS;
  localparam logic [15:0] LD_LAST_IDX = 16'(LD_WORDS - 1);
`endif

  localparam logic [2:0] SV_LAST_WI = 3'(SV_WORDS - 1);

endpackage

// File: rtl/mbc_rtc_backup_seq_if.sv
// Load stream, RTC register write bus and save stream between the HPS save
// handler, the sequencer (master) and the mapper/host side (slave).
interface mbc_rtc_backup_seq_if;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        bk_rtc_wr;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic        sv_valid;
  logic [15:0] sv_data;
  logic        sv_ready;

  modport master (
    input  ld_valid, ld_data, sv_ready,
    output ld_ready, bk_rtc_wr, bk_addr, bk_data, sv_valid, sv_data
  );

  modport slave (
    output ld_valid, ld_data, sv_ready,
    input  ld_ready, bk_rtc_wr, bk_addr, bk_data, sv_valid, sv_data
  );
endinterface

// File: rtl/mbc_rtc_word_ser.sv
// 64-bit RTC snapshot register and valid/ready word serializer; appends the
// checksum word when MBC_RTC_CHKSUM_EN is defined.
module mbc_rtc_word_ser
  import mbc_rtc_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        snap_load,
  input  logic        flush,
  input  logic [63:0] snap_in,
  input  logic        sv_ready,
  output logic        sv_valid,
  output logic [15:0] sv_data,
  output logic        last_acc
);

  logic [63:0] snap_p1;
  logic        active_p1;
  logic [2:0]  widx_p1;
  logic [15:0] word;
  logic        acc;

  always_comb begin
    word = 16'h0000;
    case (widx_p1)
      WI_TS_LO: word = snap_p1[15:0];
      WI_TS_HI: word = snap_p1[31:16];
      WI_ST_LO: word = snap_p1[47:32];
      WI_ST_HI: word = snap_p1[63:48];
`ifdef MBC_RTC_CHKSUM_EN
      WI_CHK:   word = rtc_chk(snap_p1);
`endif
      default:  word = 16'h0000;
    endcase
  end

  assign acc      = active_p1 && sv_ready;
  assign last_acc = acc && (widx_p1 == SV_LAST_WI);
  assign sv_valid = active_p1;
  assign sv_data  = active_p1 ? word : 16'h0000;

  // Snapshot stage: live RTC inputs are only sampled on snap_load
  always_ff @(posedge clk_sys) begin
    if (snap_load) snap_p1 <= snap_in;
  end

  // Word index advances on every accepted word, so there is no bubble
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      active_p1 <= 1'b0;
      widx_p1   <= 3'd0;
    end else if (flush) begin
      active_p1 <= 1'b0;
      widx_p1   <= 3'd0;
    end else if (snap_load) begin
      active_p1 <= 1'b1;
      widx_p1   <= 3'd0;
    end else if (acc) begin
      if (last_acc) begin
        active_p1 <= 1'b0;
        widx_p1   <= 3'd0;
      end else begin
        widx_p1   <= widx_p1 + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mbc_rtc_backup_seq.sv
// RTC backup sequencer: load trailer words into RTC registers 0-3 plus commit,
// or snapshot and stream the live RTC state. Checksum word via MBC_RTC_CHKSUM_EN.
module mbc_rtc_backup_seq
  import mbc_rtc_pkg::*;
(
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        ld_req,
  input  logic                        save_req,
  input  logic                        rtc_inuse,
  input  logic [31:0]                 rtc_timestamp,
  input  logic [47:0]                 rtc_savedtime,
  input  logic                        abort,
  mbc_rtc_backup_seq_if.master        bus,
  output logic                        busy,
  output logic                        ld_done,
  output logic                        ld_err,
  output logic                        save_done
);

  seq_state_e  state_q, state_d;
  logic        pend_ld_q, pend_ld_d;
  logic        pend_sv_q, pend_sv_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic        bk_wr_p1, bk_wr_d;
  logic [16:0] bk_addr_p1, bk_addr_d;
  logic [15:0] bk_data_p1, bk_data_d;
  logic        ld_done_q, ld_done_d;
  logic        ld_err_q, ld_err_d;
  logic        save_done_q, save_done_d;
  logic        ld_hs;
  logic        in_load;
  logic        snap_load, ser_flush, ser_last;
  logic        unused_savedtime_hi;

  assign unused_savedtime_hi = ^rtc_savedtime[47:32];

  assign ld_hs   = (state_q == LD_WORD) && bus.ld_valid;
  assign in_load = (state_q == LD_WORD) || (state_q == LD_COMMIT) || (state_q == LD_FIN);

  always_comb begin
    state_d     = state_q;
    pend_ld_d   = pend_ld_q;
    pend_sv_d   = pend_sv_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    bk_wr_d     = 1'b0;
    bk_addr_d   = 17'd0;
    bk_data_d   = 16'h0000;
    ld_done_d   = 1'b0;
    ld_err_d    = 1'b0;
    save_done_d = 1'b0;
    snap_load   = 1'b0;
    ser_flush   = 1'b0;

    // Requests seen while busy are remembered; a repeat just re-sets the flag
    if (state_q != IDLE) begin
      if (ld_req)   pend_ld_d = 1'b1;
      if (save_req) pend_sv_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        idx_d = 16'd0;
        sum_d = CHK_INIT;
        if (ld_req || pend_ld_q) begin
          state_d   = LD_WORD;
          pend_ld_d = 1'b0;
          if (save_req) pend_sv_d = 1'b1;
        end else if (save_req || pend_sv_q) begin
          state_d   = SV_SNAP;
          pend_sv_d = 1'b0;
        end
      end
      LD_WORD: begin
        if (ld_hs) begin
          idx_d = idx_q + 16'd1;
`ifdef MBC_RTC_CHKSUM_EN
          if (idx_q == LD_CHK_IDX) begin
            if (bus.ld_data == ~sum_q) begin
              state_d = LD_COMMIT;
            end else begin
              ld_err_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            bk_wr_d   = 1'b1;
            bk_addr_d = {1'b0, idx_q};
            bk_data_d = bus.ld_data;
            sum_d     = sum_q + bus.ld_data;
          end
`else
          bk_wr_d   = 1'b1;
          bk_addr_d = {1'b0, idx_q};
          bk_data_d = bus.ld_data;
          sum_d     = sum_q + bus.ld_data;
          if (idx_q == LD_LAST_IDX) state_d = LD_COMMIT;
`endif
        end
      end
      LD_COMMIT: begin
        bk_wr_d   = 1'b1;
        bk_addr_d = COMMIT_BK_ADDR;
        state_d   = LD_FIN;
      end
      LD_FIN: begin
        ld_done_d = 1'b1;
        state_d   = IDLE;
      end
      SV_SNAP: begin
        if (!rtc_inuse) begin
          save_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          snap_load = 1'b1;
          state_d   = SV_WORD;
        end
      end
      SV_WORD: begin
        if (ser_last) state_d = SV_FIN;
      end
      SV_FIN: begin
        save_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort beats everything issued this cycle, including a same-cycle handshake
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      pend_ld_d   = 1'b0;
      pend_sv_d   = 1'b0;
      bk_wr_d     = 1'b0;
      bk_addr_d   = 17'd0;
      bk_data_d   = 16'h0000;
      ld_done_d   = 1'b0;
      save_done_d = 1'b0;
      snap_load   = 1'b0;
      ser_flush   = 1'b1;
      ld_err_d    = in_load;
    end
  end

  // Write/status stage: RTC writes land one cycle after their handshake
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_ld_q   <= 1'b0;
      pend_sv_q   <= 1'b0;
      idx_q       <= 16'd0;
      sum_q       <= CHK_INIT;
      bk_wr_p1    <= 1'b0;
      bk_addr_p1  <= 17'd0;
      bk_data_p1  <= 16'h0000;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      save_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_ld_q   <= pend_ld_d;
      pend_sv_q   <= pend_sv_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      bk_wr_p1    <= bk_wr_d;
      bk_addr_p1  <= bk_addr_d;
      bk_data_p1  <= bk_data_d;
      ld_done_q   <= ld_done_d;
      ld_err_q    <= ld_err_d;
      save_done_q <= save_done_d;
    end
  end

  mbc_rtc_word_ser u_ser (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .snap_load (snap_load),
    .flush     (ser_flush),
    .snap_in   ({rtc_savedtime[31:0], rtc_timestamp}),
    .sv_ready  (bus.sv_ready),
    .sv_valid  (bus.sv_valid),
    .sv_data   (bus.sv_data),
    .last_acc  (ser_last)
  );

  assign bus.ld_ready  = (state_q == LD_WORD);
  assign bus.bk_rtc_wr = bk_wr_p1;
  assign bus.bk_addr   = bk_addr_p1;
  assign bus.bk_data   = bk_data_p1;
  assign busy          = (state_q != IDLE);
  assign ld_done       = ld_done_q;
  assign ld_err        = ld_err_q;
  assign save_done     = save_done_q;

endmodule

// File: tb/tb_mbc_rtc_backup_seq.sv
// Directed bench for mbc_rtc_backup_seq; expected words follow MBC_RTC_CHKSUM_EN.
module tb_mbc_rtc_backup_seq;

`ifdef MBC_RTC_CHKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n, ld_req, save_req, rtc_inuse, abort;
  logic [31:0] rtc_timestamp;
  logic [47:0] rtc_savedtime;
  logic        busy, ld_done, ld_err, save_done;

  mbc_rtc_backup_seq_if bus();

  mbc_rtc_backup_seq dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ld_req        (ld_req),
    .save_req      (save_req),
    .rtc_inuse     (rtc_inuse),
    .rtc_timestamp (rtc_timestamp),
    .rtc_savedtime (rtc_savedtime),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .ld_done       (ld_done),
    .ld_err        (ld_err),
    .save_done     (save_done)
  );

  // Hand-computed: 0x3456+0x6512+0x3ABC+0x0012 = 0xD436, ~0xD436 = 0x2BC9
  logic [15:0] exp_w [5] = '{16'h3456, 16'h6512, 16'h3ABC, 16'h0012, 16'h2BC9};

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [16:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  logic [15:0] sv_words[$];
  int          sv_cyc  [$];
  int n_ld_done = 0, n_ld_err = 0, n_sv_done = 0, n_sv_valid = 0, n_hold_err = 0, n_busy = 0;
  int ld_done_cyc = 0, sv_done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  always @(negedge clk_sys) begin
    if (bus.bk_rtc_wr) begin
      wr_addr.push_back(bus.bk_addr);
      wr_data.push_back(bus.bk_data);
      wr_cyc.push_back(cyc);
    end
    if (ld_done) begin n_ld_done++; ld_done_cyc = cyc; end
    if (ld_err) n_ld_err++;
    if (save_done) begin n_sv_done++; sv_done_cyc = cyc; end
    if (busy) n_busy++;
    if (bus.sv_valid) n_sv_valid++;
    if (bus.sv_valid && bus.sv_ready) begin
      sv_words.push_back(bus.sv_data);
      sv_cyc.push_back(cyc);
    end
    if (reset_n) begin
      if (prev_stall && (bus.sv_valid !== 1'b1 || bus.sv_data !== prev_data)) n_hold_err++;
      prev_stall = bus.sv_valid && !bus.sv_ready;
      prev_data  = bus.sv_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic feed_words(input int n, input logic [15:0] last_w);
    for (int k = 0; k < n; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = (k == n - 1) ? last_w : exp_w[k];
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_data  = 16'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ld_req = 0; save_req = 0; rtc_inuse = 0; abort = 0;
    rtc_timestamp = 32'h0; rtc_savedtime = 48'h0;
    bus.ld_valid = 0; bus.ld_data = 16'h0; bus.sv_ready = 0;
    repeat (3) tick();
    n_total++; if ({bus.ld_ready, bus.bk_rtc_wr, bus.sv_valid, busy, ld_done, ld_err, save_done} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.ld_ready, bus.bk_rtc_wr, bus.sv_valid, busy, ld_done, ld_err, save_done}); else n_pass++;
    n_total++; if (bus.bk_addr !== 17'h0) $display("FAIL reset_bk_addr: got %h want 0", bus.bk_addr); else n_pass++;
    n_total++; if (bus.bk_data !== 16'h0) $display("FAIL reset_bk_data: got %h want 0", bus.bk_data); else n_pass++;
    n_total++; if (bus.sv_data !== 16'h0) $display("FAIL reset_sv_data: got %h want 0", bus.sv_data); else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_load();
    int w0, d0, e0;
    w0 = wr_addr.size(); d0 = n_ld_done; e0 = n_ld_err;
    ld_req = 1'b1; tick(); ld_req = 1'b0;
    n_total++; if (bus.ld_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", bus.ld_ready); else n_pass++;
    feed_words(NW, exp_w[NW-1]);
    for (int i = 0; i < 10 && n_ld_done == d0; i++) tick();
    tick();
    n_total++; if (wr_addr.size() - w0 !== 5) $display("FAIL load_nwr: got %0d want 5", wr_addr.size() - w0);
    else begin
      n_pass++;
      for (int k = 0; k < 5; k++) begin
        n_total++; if (wr_addr[w0+k] !== 17'(k)) $display("FAIL load_addr%0d: got %h want %h", k, wr_addr[w0+k], 17'(k)); else n_pass++;
        n_total++; if (wr_data[w0+k] !== ((k < 4) ? exp_w[k] : 16'h0)) $display("FAIL load_data%0d: got %h want %h", k, wr_data[w0+k], (k < 4) ? exp_w[k] : 16'h0); else n_pass++;
        n_total++; if (wr_cyc[w0+k] - wr_cyc[w0] !== ((k < 4) ? k : NW)) $display("FAIL load_cyc%0d: got %0d want %0d", k, wr_cyc[w0+k] - wr_cyc[w0], (k < 4) ? k : NW); else n_pass++;
      end
      n_total++; if (ld_done_cyc <= wr_cyc[w0+4]) $display("FAIL load_done_order: got %0d want > %0d", ld_done_cyc, wr_cyc[w0+4]); else n_pass++;
    end
    n_total++; if (n_ld_done - d0 !== 1) $display("FAIL load_done_cnt: got %0d want 1", n_ld_done - d0); else n_pass++;
    n_total++; if (n_ld_err - e0 !== 0) $display("FAIL load_err_cnt: got %0d want 0", n_ld_err - e0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL load_busy_end: got %b want 0", busy); else n_pass++;
  endtask

`ifdef MBC_RTC_CHKSUM_EN
  task automatic test_chk_bad();
    int w0, d0, e0;
    w0 = wr_addr.size(); d0 = n_ld_done; e0 = n_ld_err;
    ld_req = 1'b1; tick(); ld_req = 1'b0;
    feed_words(5, 16'h2BC8);
    repeat (4) tick();
    n_total++; if (wr_addr.size() - w0 !== 4) $display("FAIL chk_nwr: got %0d want 4", wr_addr.size() - w0); else n_pass++;
    n_total++; if (wr_addr[$] !== 17'h3) $display("FAIL chk_last_addr: got %h want 3", wr_addr[$]); else n_pass++;
    n_total++; if (n_ld_err - e0 !== 1) $display("FAIL chk_err_cnt: got %0d want 1", n_ld_err - e0); else n_pass++;
    n_total++; if (n_ld_done - d0 !== 0) $display("FAIL chk_done_cnt: got %0d want 0", n_ld_done - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL chk_busy: got %b want 0", busy); else n_pass++;
  endtask
`endif

  task automatic test_save();
    int s0, sd0, h0;
    s0 = sv_words.size(); sd0 = n_sv_done; h0 = n_hold_err;
    rtc_inuse = 1'b1; rtc_timestamp = 32'h65123456; rtc_savedtime = 48'h000000123ABC;
    bus.sv_ready = 1'b0;
    save_req = 1'b1; tick(); save_req = 1'b0;
    for (int i = 0; i < 60 && n_sv_done == sd0; i++) begin
      bus.sv_ready = i[0];
      if (sv_words.size() > s0) begin
        rtc_timestamp = 32'hDEADBEEF; rtc_savedtime = 48'hFFFF_CAFE_F00D;
      end
      tick();
    end
    bus.sv_ready = 1'b0;
    n_total++; if (sv_words.size() - s0 !== NW) $display("FAIL save_nwords: got %0d want %0d", sv_words.size() - s0, NW);
    else begin
      n_pass++;
      for (int k = 0; k < NW; k++) begin
        n_total++; if (sv_words[s0+k] !== exp_w[k]) $display("FAIL save_word%0d: got %h want %h", k, sv_words[s0+k], exp_w[k]); else n_pass++;
      end
    end
    n_total++; if (n_hold_err - h0 !== 0) $display("FAIL save_hold: got %0d unstable stalls want 0", n_hold_err - h0); else n_pass++;
    n_total++; if (n_sv_done - sd0 !== 1) $display("FAIL save_done_cnt: got %0d want 1", n_sv_done - sd0); else n_pass++;
  endtask

  task automatic test_skip();
    int v0, sd0;
    logic found;
    v0 = n_sv_valid; sd0 = n_sv_done; found = 1'b0;
    rtc_inuse = 1'b0; bus.sv_ready = 1'b1;
    save_req = 1'b1; tick(); save_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (save_done) found = 1'b1;
    end
    repeat (3) tick();
    bus.sv_ready = 1'b0;
    n_total++; if (found !== 1'b1) $display("FAIL skip_done_2cyc: got %b want 1", found); else n_pass++;
    n_total++; if (n_sv_valid - v0 !== 0) $display("FAIL skip_sv_valid: got %0d cycles want 0", n_sv_valid - v0); else n_pass++;
    n_total++; if (n_sv_done - sd0 !== 1) $display("FAIL skip_done_cnt: got %0d want 1", n_sv_done - sd0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w0, s0, d0, sd0;
    w0 = wr_addr.size(); s0 = sv_words.size(); d0 = n_ld_done; sd0 = n_sv_done;
    rtc_inuse = 1'b1; rtc_timestamp = 32'h65123456; rtc_savedtime = 48'h000000123ABC;
    bus.sv_ready = 1'b1;
    ld_req = 1'b1; save_req = 1'b1; tick(); ld_req = 1'b0; save_req = 1'b0;
    feed_words(NW, exp_w[NW-1]);
    for (int i = 0; i < 40 && n_sv_done == sd0; i++) tick();
    bus.sv_ready = 1'b0;
    tick();
    n_total++; if (wr_addr.size() - w0 !== 5) $display("FAIL b2b_nwr: got %0d want 5", wr_addr.size() - w0);
    else begin
      n_pass++;
      n_total++; if (wr_addr[w0+4] !== 17'h4) $display("FAIL b2b_commit_addr: got %h want 4", wr_addr[w0+4]); else n_pass++;
    end
    n_total++; if (n_ld_done - d0 !== 1) $display("FAIL b2b_ld_done: got %0d want 1", n_ld_done - d0); else n_pass++;
    n_total++; if (sv_words.size() - s0 !== NW) $display("FAIL b2b_nwords: got %0d want %0d", sv_words.size() - s0, NW);
    else begin
      n_pass++;
      n_total++; if (sv_cyc[s0] <= ld_done_cyc) $display("FAIL b2b_order: got save cyc %0d want > %0d", sv_cyc[s0], ld_done_cyc); else n_pass++;
      n_total++; if (sv_words[s0+NW-1] !== exp_w[NW-1]) $display("FAIL b2b_last_word: got %h want %h", sv_words[s0+NW-1], exp_w[NW-1]); else n_pass++;
    end
    n_total++; if (n_sv_done - sd0 !== 1) $display("FAIL b2b_save_done: got %0d want 1", n_sv_done - sd0); else n_pass++;
  endtask

  task automatic test_abort();
    int w0, d0, e0;
    w0 = wr_addr.size(); d0 = n_ld_done; e0 = n_ld_err;
    ld_req = 1'b1; tick(); ld_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = exp_w[k]; tick();
    end
    abort = 1'b1; bus.ld_data = exp_w[2]; tick();
    abort = 1'b0; bus.ld_valid = 1'b0;
    repeat (5) tick();
    n_total++; if (wr_addr.size() - w0 !== 2) $display("FAIL abort_nwr: got %0d want 2", wr_addr.size() - w0);
    else begin
      n_pass++;
      n_total++; if (wr_addr[w0+1] !== 17'h1) $display("FAIL abort_addr1: got %h want 1", wr_addr[w0+1]); else n_pass++;
    end
    n_total++; if (n_ld_err - e0 !== 1) $display("FAIL abort_err_cnt: got %0d want 1", n_ld_err - e0); else n_pass++;
    n_total++; if (n_ld_done - d0 !== 0) $display("FAIL abort_done_cnt: got %0d want 0", n_ld_done - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_save();
    int b0;
    rtc_inuse = 1'b1; rtc_timestamp = 32'h65123456; rtc_savedtime = 48'h000000123ABC;
    bus.sv_ready = 1'b0;
    save_req = 1'b1; tick(); save_req = 1'b0;
    for (int i = 0; i < 10 && !bus.sv_valid; i++) tick();
    n_total++; if (bus.sv_valid !== 1'b1) $display("FAIL rst_save_started: got %b want 1", bus.sv_valid); else n_pass++;
    ld_req = 1'b1; save_req = 1'b1; tick(); ld_req = 1'b0; save_req = 1'b0;
    reset_n = 1'b0; tick();
    n_total++; if (bus.sv_valid !== 1'b0) $display("FAIL rst_sv_valid: got %b want 0", bus.sv_valid); else n_pass++;
    n_total++; if (bus.sv_data !== 16'h0) $display("FAIL rst_sv_data: got %h want 0", bus.sv_data); else n_pass++;
    reset_n = 1'b1;
    b0 = n_busy;
    repeat (8) tick();
    n_total++; if (n_busy - b0 !== 0) $display("FAIL rst_pending_cleared: got %0d busy cycles want 0", n_busy - b0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
`ifdef MBC_RTC_CHKSUM_EN
    test_chk_bad();
`endif
    test_save();
    test_skip();
    test_back_to_back();
    test_abort();
    test_reset_mid_save();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
